// File: rtl/leb128_stream_decoder_pkg.sv
// Shared types and helpers for the LEB128 stream decoder.
// State encoding, maximum encoded length and final-byte legality rule.
package leb128_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        HOLD  = 2'd1,
        SKIP  = 2'd2
    } state_t;

    function automatic int unsigned max_bytes(input int unsigned out_w);
        return (out_w + 6) / 7;
    endfunction

    // Bits above the n_valid usable ones must be zero (unsigned) or copies of the top usable bit (signed).
    function automatic logic final_bits_legal(input logic [6:0] payload,
                                              input int unsigned n_valid,
                                              input logic is_signed);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 7; i++) begin
            if (i >= n_valid) begin
                if (is_signed) begin
                    if (payload[i] != payload[n_valid-1]) ok = 1'b0;
                end else if (payload[i]) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/leb128_stream_decoder_if.sv
// Byte-in / value-out valid-ready bundle of the LEB128 decoder.
interface leb128_stream_decoder_if #(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned CNT_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_byte;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_value;
    logic [CNT_W-1:0] out_byte_cnt;
    logic             out_err;

    modport master (
        output in_valid, in_byte, in_signed, out_ready,
        input  in_ready, out_valid, out_value, out_byte_cnt, out_err
    );

    modport slave (
        input  in_valid, in_byte, in_signed, out_ready,
        output in_ready, out_valid, out_value, out_byte_cnt, out_err
    );
endinterface

// File: rtl/leb128_stream_decoder_result_reg.sv
// Output holding register: loads a decoded result, holds it until taken.
module leb128_result_reg #(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [OUT_W-1:0] i_value,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_err,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_value,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_err
);
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_value <= '0;
            o_cnt   <= '0;
            o_err   <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_value <= i_value;
            o_cnt   <= i_cnt;
            o_err   <= i_err;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/leb128_stream_decoder.sv
// Byte-serial LEB128 decoder (u32/s32/u64/s64), one byte per cycle in, one value out.
// Flags over-long encodings and illegal unused bits in the final byte.
module leb128_stream_decoder
    import leb128_pkg::*;
#(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned CNT_W = 4
) (
    input logic                    clk,
    input logic                    rst,
    leb128_stream_decoder_if.slave bus
);
    localparam int unsigned MAX_BYTES = max_bytes(OUT_W);
    localparam int unsigned LAST      = MAX_BYTES - 1;
    localparam int unsigned N_VALID   = OUT_W - 7 * LAST;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [OUT_W-1:0] r_acc, w_acc_n;
    logic             r_sgn, w_sgn_n;

    logic             w_take, w_first, w_last, w_cont, w_sgn, w_ext, w_legal;
    logic [6:0]       w_payload;
    int unsigned      w_shift;
    logic [OUT_W-1:0] w_placed, w_fill, w_acc_new, w_value;

    logic             w_load, w_res_err;
    logic [CNT_W-1:0] w_res_cnt;

    assign bus.in_ready = (r_state != HOLD) | bus.out_ready;
    assign w_take       = bus.in_valid & bus.in_ready;

    // HOLD also keeps r_cnt at zero, so a byte accepted there starts a fresh value.
    assign w_first   = (r_cnt == '0);
    assign w_last    = (32'(r_cnt) == LAST);
    assign w_payload = bus.in_byte[6:0];
    assign w_cont    = bus.in_byte[7];
    assign w_sgn     = w_first ? bus.in_signed : r_sgn;
    assign w_shift   = 32'(r_cnt) * 7;
    assign w_placed  = OUT_W'(w_payload) << w_shift;
    assign w_fill    = {OUT_W{1'b1}} << (w_shift + 7);
    assign w_ext     = w_sgn & w_payload[6] & ((w_shift + 7) < OUT_W);
    assign w_acc_new = (w_first ? '0 : r_acc) | w_placed;
    assign w_value   = w_acc_new | (w_ext ? w_fill : '0);
    assign w_legal   = !w_last || final_bits_legal(w_payload, N_VALID, w_sgn);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_acc_n   = r_acc;
        w_sgn_n   = r_sgn;
        w_load    = 1'b0;
        w_res_cnt = '0;
        w_res_err = 1'b0;
        case (r_state)
            ACCUM, HOLD: begin
                if (r_state == HOLD && bus.out_ready) w_state_n = ACCUM;
                if (w_take) begin
                    w_sgn_n = w_sgn;
                    if (!w_cont) begin
                        w_load    = 1'b1;
                        w_res_cnt = r_cnt + 1'b1;
                        w_res_err = !w_legal;
                        w_cnt_n   = '0;
                        w_acc_n   = '0;
                        w_state_n = HOLD;
                    end else if (w_last) begin
                        w_load    = 1'b1;
                        w_res_cnt = CNT_W'(MAX_BYTES);
                        w_res_err = 1'b1;
                        w_cnt_n   = '0;
                        w_acc_n   = '0;
                        w_state_n = SKIP;
                    end else begin
                        w_acc_n   = w_acc_new;
                        w_cnt_n   = r_cnt + 1'b1;
                        w_state_n = ACCUM;
                    end
                end
            end
            SKIP: begin
                // An error result still pending at the end of the tail must keep blocking input.
                if (w_take && !w_cont)
                    w_state_n = (bus.out_valid && !bus.out_ready) ? HOLD : ACCUM;
            end
            default: w_state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sgn   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_acc   <= w_acc_n;
            r_sgn   <= w_sgn_n;
        end
    end

    leb128_result_reg #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_result (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_value),
        .i_cnt   (w_res_cnt),
        .i_err   (w_res_err),
        .i_ready (bus.out_ready),
        .o_valid (bus.out_valid),
        .o_value (bus.out_value),
        .o_cnt   (bus.out_byte_cnt),
        .o_err   (bus.out_err)
    );
endmodule

// File: tb/tb_leb128_stream_decoder.sv
// Bench for leb128_stream_decoder: directed cases plus random streams for OUT_W=32 and 64,
// checked against an arbitrary-precision decode model.
module tb_leb128_stream_decoder;

    typedef struct packed {
        logic [63:0] v;
        logic [3:0]  c;
        logic        e;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_byte = 8'h00;
    logic       tb_signed = 1'b0;
    logic       out_rdy = 1'b1;
    logic       sel64 = 1'b0;
    logic       ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    res_t       obs32[$];
    res_t       obs64[$];
    logic [7:0] sb[$];
    logic       ss[$];

    leb128_stream_decoder_if #(.OUT_W(32), .CNT_W(4)) if32 ();
    leb128_stream_decoder_if #(.OUT_W(64), .CNT_W(4)) if64 ();

    leb128_stream_decoder #(.OUT_W(32), .CNT_W(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    leb128_stream_decoder #(.OUT_W(64), .CNT_W(4)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    assign if32.in_valid  = tb_valid & ~sel64;
    assign if32.in_byte   = tb_byte;
    assign if32.in_signed = tb_signed;
    assign if32.out_ready = out_rdy;
    assign if64.in_valid  = tb_valid & sel64;
    assign if64.in_byte   = tb_byte;
    assign if64.in_signed = tb_signed;
    assign if64.out_ready = out_rdy;
    assign ready = sel64 ? if64.in_ready : if32.in_ready;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (if32.out_valid && if32.out_ready)
                obs32.push_back({64'(if32.out_value), if32.out_byte_cnt, if32.out_err});
            if (if64.out_valid && if64.out_ready)
                obs64.push_back({if64.out_value, if64.out_byte_cnt, if64.out_err});
        end
    end

    // Present one byte and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [7:0] b, input logic s, input bit rand_rdy);
        int t;
        bit ok;
        t = 0;
        ok = 1'b0;
        tb_valid = 1'b1;
        tb_byte = b;
        tb_signed = s;
        while (!ok && t < 1000) begin
            if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = ready;
            @(posedge clk);
            #1;
            t++;
        end
        tb_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b required 1 for byte %h", ready, b);
        end
    endtask

    task automatic flush();
        tb_valid = 1'b0;
        out_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        sb.push_back(b);
        ss.push_back(1'($urandom_range(0, 1)));
    endtask

    // Decode the whole stream sb/ss as integers of unbounded width, then range-check against W.
    task automatic model(input int w, output res_t q[$]);
        int mx, i, n;
        bit s, done, ok;
        logic [127:0] v, top;
        logic [7:0] b;
        res_t r;
        mx = (w + 6) / 7;
        i = 0;
        q = {};
        while (i < sb.size()) begin
            v = '0;
            n = 0;
            s = ss[i];
            done = 1'b0;
            while (!done) begin
                b = sb[i+n];
                v = v | (128'(b[6:0]) << (7 * n));
                n++;
                if (!b[7]) begin
                    if (s && b[6]) v = v | ({128{1'b1}} << (7 * n));
                    top = v >> (w - 1);
                    if (s) ok = (top == '0) || (top == ({128{1'b1}} >> (w - 1)));
                    else   ok = ((v >> w) == '0);
                    r.v = (w == 32) ? {32'h0, v[31:0]} : v[63:0];
                    r.c = 4'(n);
                    r.e = !ok;
                    q.push_back(r);
                    i += n;
                    done = 1'b1;
                end else if (n == mx) begin
                    r.v = '0;
                    r.c = 4'(mx);
                    r.e = 1'b1;
                    q.push_back(r);
                    i += n;
                    while (sb[i][7]) i++;
                    i++;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic build(input int w, input int nvals);
        int mx, nv, len;
        logic [6:0] p, mask;
        mx = (w + 6) / 7;
        nv = w - 7 * (mx - 1);
        mask = 7'((1 << nv) - 1);
        sb.delete();
        ss.delete();
        for (int k = 0; k < nvals; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int j = 0; j < mx; j++) push_byte({1'b1, 7'($urandom)});
                len = $urandom_range(0, 2);
                for (int j = 0; j < len; j++) push_byte({1'b1, 7'($urandom)});
                push_byte({1'b0, 7'($urandom)});
            end else begin
                len = $urandom_range(1, mx);
                for (int j = 0; j < len - 1; j++) push_byte({1'b1, 7'($urandom)});
                p = 7'($urandom);
                if (len == mx && $urandom_range(0, 2) != 0)
                    p = $urandom_range(0, 1) ? (p | ~mask) : (p & mask);
                push_byte({1'b0, p});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if32.out_valid); end
        n_checks++;
        if (if32.out_value !== 32'h0) begin n_fail++; $display("FAIL reset_value: got %h want 0", if32.out_value); end
        n_checks++;
        if (if32.out_byte_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", if32.out_byte_cnt); end
        n_checks++;
        if (if32.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", if32.out_err); end
        n_checks++;
        if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", if32.in_ready); end
        n_checks++;
        if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid64: got %b want 0", if64.out_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_unsigned32();
        sel64 = 1'b0;
        out_rdy = 1'b1;
        send(8'hE5, 1'b0, 1'b0);
        send(8'h8E, 1'b0, 1'b0);
        n_checks++;
        if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL u32_early_valid: got %b want 0", if32.out_valid); end
        send(8'h26, 1'b0, 1'b0);
        n_checks++;
        if (if32.out_valid !== 1'b1) begin n_fail++; $display("FAIL u32_latency: out_valid got %b want 1", if32.out_valid); end
        n_checks++;
        if (if32.out_value !== 32'h00098765) begin n_fail++; $display("FAIL u32_value: got %h want 00098765", if32.out_value); end
        n_checks++;
        if (if32.out_byte_cnt !== 4'd3 || if32.out_err !== 1'b0) begin
            n_fail++; $display("FAIL u32_cnt_err: got cnt=%0d err=%b want cnt=3 err=0", if32.out_byte_cnt, if32.out_err);
        end
        flush();
    endtask

    task automatic test_signed32();
        send(8'hC0, 1'b1, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'h78, 1'b0, 1'b0);
        n_checks++;
        if (if32.out_value !== 32'hFFFE1DC0 || if32.out_byte_cnt !== 4'd3 || if32.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL s32_value: got %h cnt=%0d err=%b want FFFE1DC0 cnt=3 err=0",
                     if32.out_value, if32.out_byte_cnt, if32.out_err);
        end
        send(8'h7F, 1'b1, 1'b0);
        n_checks++;
        if (if32.out_value !== 32'hFFFFFFFF || if32.out_byte_cnt !== 4'd1) begin
            n_fail++; $display("FAIL s32_single: got %h cnt=%0d want FFFFFFFF cnt=1", if32.out_value, if32.out_byte_cnt);
        end
        flush();
    endtask

    task automatic test_final_byte();
        for (int j = 0; j < 4; j++) send(8'hFF, 1'b0, 1'b0);
        send(8'h0F, 1'b0, 1'b0);
        n_checks++;
        if (if32.out_value !== 32'hFFFFFFFF || if32.out_byte_cnt !== 4'd5 || if32.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL final_u_legal: got %h cnt=%0d err=%b want FFFFFFFF cnt=5 err=0",
                     if32.out_value, if32.out_byte_cnt, if32.out_err);
        end
        for (int j = 0; j < 4; j++) send(8'hFF, 1'b0, 1'b0);
        send(8'h1F, 1'b0, 1'b0);
        n_checks++;
        if (if32.out_err !== 1'b1 || if32.out_byte_cnt !== 4'd5) begin
            n_fail++; $display("FAIL final_u_illegal: got err=%b cnt=%0d want err=1 cnt=5", if32.out_err, if32.out_byte_cnt);
        end
        send(8'hFF, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) send(8'hFF, 1'b0, 1'b0);
        send(8'h7F, 1'b0, 1'b0);
        n_checks++;
        if (if32.out_value !== 32'hFFFFFFFF || if32.out_err !== 1'b0) begin
            n_fail++; $display("FAIL final_s_legal: got %h err=%b want FFFFFFFF err=0", if32.out_value, if32.out_err);
        end
        flush();
    endtask

    task automatic test_overlong();
        obs32.delete();
        for (int j = 0; j < 4; j++) send(8'h80, 1'b0, 1'b0);
        out_rdy = 1'b0;
        send(8'h80, 1'b0, 1'b0);
        n_checks++;
        if (if32.out_valid !== 1'b1 || if32.out_err !== 1'b1 || if32.out_byte_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL overlong_result: got valid=%b err=%b cnt=%0d want 1 1 5",
                     if32.out_valid, if32.out_err, if32.out_byte_cnt);
        end
        send(8'h80, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        n_checks++;
        if (if32.out_valid !== 1'b1 || if32.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL overlong_hold: got valid=%b in_ready=%b want 1 0", if32.out_valid, if32.in_ready);
        end
        out_rdy = 1'b1;
        send(8'h05, 1'b0, 1'b0);
        flush();
        n_checks++;
        if (obs32.size() != 2) begin
            n_fail++; $display("FAIL overlong_count: got %0d results want 2", obs32.size());
        end else begin
            n_checks++;
            if (obs32[0].e !== 1'b1 || obs32[0].c !== 4'd5) begin
                n_fail++; $display("FAIL overlong_first: got err=%b cnt=%0d want 1 5", obs32[0].e, obs32[0].c);
            end
            n_checks++;
            if (obs32[1] !== {64'd5, 4'd1, 1'b0}) begin
                n_fail++; $display("FAIL overlong_next: got %h cnt=%0d err=%b want 5 1 0", obs32[1].v, obs32[1].c, obs32[1].e);
            end
        end
    endtask

    task automatic test_backpressure();
        obs32.delete();
        out_rdy = 1'b0;
        send(8'h02, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (if32.out_valid !== 1'b1 || if32.out_value !== 32'd2 || if32.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got valid=%b value=%h in_ready=%b want 1 2 0",
                         if32.out_valid, if32.out_value, if32.in_ready);
            end
            @(posedge clk);
            #1;
        end
        tb_valid = 1'b1;
        tb_byte = 8'h03;
        tb_signed = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", if32.in_ready); end
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        n_checks++;
        if (if32.out_valid !== 1'b1 || if32.out_value !== 32'd3) begin
            n_fail++; $display("FAIL bp_overlap: got valid=%b value=%h want 1 3", if32.out_valid, if32.out_value);
        end
        flush();
        n_checks++;
        if (obs32.size() != 2 || obs32[0].v !== 64'd2 || obs32[1].v !== 64'd3) begin
            n_fail++; $display("FAIL bp_sequence: got %0d results want values 2,3", obs32.size());
        end
    endtask

    task automatic test_back_to_back();
        res_t exp[$];
        int c0;
        obs32.delete();
        build(32, 20);
        model(32, exp);
        out_rdy = 1'b1;
        c0 = cyc;
        foreach (sb[j]) send(sb[j], ss[j], 1'b0);
        n_checks++;
        if (cyc - c0 != sb.size()) begin
            n_fail++; $display("FAIL b2b_throughput: got %0d cycles want %0d", cyc - c0, sb.size());
        end
        flush();
        n_checks++;
        if (obs32.size() != exp.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs32.size(), exp.size());
        end
        for (int j = 0; j < exp.size() && j < obs32.size(); j++) begin
            n_checks++;
            if (obs32[j].e !== exp[j].e || obs32[j].c !== exp[j].c || (!exp[j].e && obs32[j].v !== exp[j].v)) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got %h cnt=%0d err=%b want %h cnt=%0d err=%b",
                         j, obs32[j].v, obs32[j].c, obs32[j].e, exp[j].v, exp[j].c, exp[j].e);
            end
        end
    endtask

    task automatic test_reset_mid();
        send(8'h81, 1'b0, 1'b0);
        send(8'h82, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h07, 1'b0, 1'b0);
        n_checks++;
        if (if32.out_value !== 32'd7 || if32.out_byte_cnt !== 4'd1 || if32.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h cnt=%0d err=%b want 7 1 0", if32.out_value, if32.out_byte_cnt, if32.out_err);
        end
        flush();
    endtask

    task automatic test_wide64();
        sel64 = 1'b1;
        for (int j = 0; j < 9; j++) send(8'hFF, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        n_checks++;
        if (if64.out_value !== 64'hFFFFFFFFFFFFFFFF || if64.out_byte_cnt !== 4'd10 || if64.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wide64: got %h cnt=%0d err=%b want FFFFFFFFFFFFFFFF 10 0",
                     if64.out_value, if64.out_byte_cnt, if64.out_err);
        end
        flush();
        sel64 = 1'b0;
    endtask

    task automatic test_random(input int w);
        res_t exp[$];
        res_t got[$];
        sel64 = (w == 64);
        obs32.delete();
        obs64.delete();
        build(w, 40);
        model(w, exp);
        foreach (sb[j]) send(sb[j], ss[j], 1'b1);
        flush();
        got = sel64 ? obs64 : obs32;
        n_checks++;
        if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", w, got.size(), exp.size());
        end
        for (int j = 0; j < exp.size() && j < got.size(); j++) begin
            n_checks++;
            if (got[j].e !== exp[j].e || got[j].c !== exp[j].c || (!exp[j].e && got[j].v !== exp[j].v)) begin
                n_fail++;
                $display("FAIL rand%0d_result[%0d]: got %h cnt=%0d err=%b want %h cnt=%0d err=%b",
                         w, j, got[j].v, got[j].c, got[j].e, exp[j].v, exp[j].c, exp[j].e);
            end
        end
        sel64 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned32();
        test_signed32();
        test_final_byte();
        test_overlong();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wide64();
        test_random(32);
        test_random(64);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
